// File: rtl/blinker_nios2_proc_dct_pkg.sv
// Shared types and sizing for the Nios II OCI data-capture trace (DCT) controller.
package blinker_nios2_proc_dct_pkg;

   localparam int DCT_FRAME_W = 3;
   localparam int DCT_DEPTH   = 10;
   localparam int DCT_CNT_W   = 4;
   localparam int DCT_BUF_W   = DCT_FRAME_W * DCT_DEPTH;

   typedef enum logic [1:0] {
      ST_FILL  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } dct_state_e;

endpackage

// File: rtl/blinker_nios2_proc_dct_ctrl_if.sv
// Trace capture / trace sink bus of the DCT controller. The controller is the
// slave; the capture logic plus sink (or a bench) is the master.
interface blinker_nios2_proc_dct_ctrl_if #(
   parameter int FRAME_W = blinker_nios2_proc_dct_pkg::DCT_FRAME_W,
   parameter int DEPTH   = blinker_nios2_proc_dct_pkg::DCT_DEPTH,
   parameter int CNT_W   = blinker_nios2_proc_dct_pkg::DCT_CNT_W
);
   localparam int BUF_W = FRAME_W * DEPTH;

   logic               in_valid;
   logic               in_ready;
   logic [FRAME_W-1:0] in_frame;
   logic               flush_req;
   logic               test_ending;
   logic               out_valid;
   logic               out_ready;
   logic [BUF_W-1:0]   out_data;
   logic [CNT_W-1:0]   out_count;
   logic [BUF_W-1:0]   dct_buffer;
   logic [CNT_W-1:0]   dct_count;
   logic               test_has_ended;

   modport master (
      output in_valid, in_frame, flush_req, test_ending, out_ready,
      input  in_ready, out_valid, out_data, out_count, dct_buffer, dct_count, test_has_ended
   );

   modport slave (
      input  in_valid, in_frame, flush_req, test_ending, out_ready,
      output in_ready, out_valid, out_data, out_count, dct_buffer, dct_count, test_has_ended
   );

endinterface

// File: rtl/blinker_nios2_proc_dct_shift.sv
// DCT packing shift register and frame counter; newest frame enters the LSBs.
// next_* expose the post-accept contents so the controller can snapshot them.
module blinker_nios2_proc_dct_shift
   import blinker_nios2_proc_dct_pkg::*;
#(
   parameter int FRAME_W = DCT_FRAME_W,
   parameter int DEPTH   = DCT_DEPTH,
   parameter int CNT_W   = DCT_CNT_W
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       shift_en,
   input  logic                       clear,
   input  logic [FRAME_W-1:0]         in_frame,
   output logic [FRAME_W*DEPTH-1:0]   buffer,
   output logic [CNT_W-1:0]           count,
   output logic [FRAME_W*DEPTH-1:0]   next_buffer,
   output logic [CNT_W-1:0]           next_count
);
   localparam int BUF_W = FRAME_W * DEPTH;

   // post-accept view of the buffer and count
   always_comb begin
      next_buffer = buffer;
      next_count  = count;
      if (shift_en) begin
         next_buffer = {buffer[BUF_W-FRAME_W-1:0], in_frame};
         next_count  = count + CNT_W'(1);
      end else begin
         next_buffer = buffer;
         next_count  = count;
      end
   end

   // buffer/count storage with clear on drain handshake
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         buffer <= {BUF_W{1'b0}};
         count  <= {CNT_W{1'b0}};
      end else if (clear) begin
         buffer <= {BUF_W{1'b0}};
         count  <= {CNT_W{1'b0}};
      end else begin
         buffer <= next_buffer;
         count  <= next_count;
      end
   end

endmodule

// File: rtl/blinker_nios2_proc_dct_ctrl.sv
// DCT buffer sequencer: packs trace frames, drains on full / flush / test end,
// and flags test_has_ended once the final drain has been taken by the sink.
module blinker_nios2_proc_dct_ctrl
   import blinker_nios2_proc_dct_pkg::*;
#(
   parameter int FRAME_W = DCT_FRAME_W,
   parameter int DEPTH   = DCT_DEPTH,
   parameter int CNT_W   = DCT_CNT_W
) (
   input  logic                         clk,
   input  logic                         reset_n,
   blinker_nios2_proc_dct_ctrl_if.slave bus
);
   localparam int BUF_W = FRAME_W * DEPTH;

   dct_state_e       state;
   dct_state_e       state_next;
   logic             ending_latched;
   logic             ending;
   logic             in_ready;
   logic             accept;
   logic             handshake;
   logic             drain_load;
   logic             shift_clear;
   logic             enter_done;
   logic [BUF_W-1:0] buffer;
   logic [BUF_W-1:0] next_buffer;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] next_count;
   logic             out_valid_q;
   logic [BUF_W-1:0] out_data_q;
   logic [CNT_W-1:0] out_count_q;
   logic             test_has_ended_q;

   assign accept    = bus.in_valid && in_ready;
   assign ending    = ending_latched || bus.test_ending;
   assign handshake = out_valid_q && bus.out_ready;

   blinker_nios2_proc_dct_shift #(
      .FRAME_W (FRAME_W),
      .DEPTH   (DEPTH),
      .CNT_W   (CNT_W)
   ) u_shift (
      .clk         (clk),
      .reset_n     (reset_n),
      .shift_en    (accept),
      .clear       (shift_clear),
      .in_frame    (bus.in_frame),
      .buffer      (buffer),
      .count       (count),
      .next_buffer (next_buffer),
      .next_count  (next_count)
   );

   // in_ready only depends on registered state so it never loops through in_valid
   always_comb begin
      in_ready = 1'b0;
      if ((state == ST_FILL) && !ending_latched && (count < CNT_W'(DEPTH))) begin
         in_ready = 1'b1;
      end else begin
         in_ready = 1'b0;
      end
   end

   // state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_FILL;
      end else begin
         state <= state_next;
      end
   end

   // next-state: drain decision uses the post-accept count
   always_comb begin
      state_next = state;
      case (state)
         ST_FILL: begin
            if ((next_count == CNT_W'(DEPTH)) ||
                ((bus.flush_req || ending) && (next_count != {CNT_W{1'b0}}))) begin
               state_next = ST_DRAIN;
            end else if (ending) begin
               state_next = ST_DONE;
            end else begin
               state_next = ST_FILL;
            end
         end
         ST_DRAIN: begin
            if (handshake) begin
               state_next = ending ? ST_DONE : ST_FILL;
            end else begin
               state_next = ST_DRAIN;
            end
         end
         ST_DONE:  state_next = ST_DONE;
         default:  state_next = ST_FILL;
      endcase
   end

   // control strobes derived from the transition
   always_comb begin
      drain_load  = 1'b0;
      shift_clear = 1'b0;
      enter_done  = 1'b0;
      if ((state == ST_FILL) && (state_next == ST_DRAIN)) begin
         drain_load = 1'b1;
      end else begin
         drain_load = 1'b0;
      end
      if ((state == ST_DRAIN) && handshake) begin
         shift_clear = 1'b1;
      end else begin
         shift_clear = 1'b0;
      end
      if (state_next == ST_DONE) begin
         enter_done = 1'b1;
      end else begin
         enter_done = 1'b0;
      end
   end

   // drain register, ending latch and sticky end flag
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_q      <= 1'b0;
         out_data_q       <= {BUF_W{1'b0}};
         out_count_q      <= {CNT_W{1'b0}};
         ending_latched   <= 1'b0;
         test_has_ended_q <= 1'b0;
      end else begin
         ending_latched   <= ending_latched | bus.test_ending;
         test_has_ended_q <= test_has_ended_q | enter_done;
         if (drain_load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= next_buffer;
            out_count_q <= next_count;
         end else if (shift_clear) begin
            out_valid_q <= 1'b0;
         end else begin
            out_valid_q <= out_valid_q;
         end
      end
   end

   assign bus.in_ready       = in_ready;
   assign bus.out_valid      = out_valid_q;
   assign bus.out_data       = out_data_q;
   assign bus.out_count      = out_count_q;
   assign bus.dct_buffer     = buffer;
   assign bus.dct_count      = count;
   assign bus.test_has_ended = test_has_ended_q;

endmodule
